// File: rtl/debug_burst_bridge_if.sv
// Bus interfaces used by debug_burst_bridge: the byte-wide single-cycle debug bus
// and the 64-bit burst memory port in front of the PSRAM controller.

interface debug_bus_if;
    logic [15:0] addr;
    logic [7:0]  write_data;
    logic        write_enable;
    logic        read_enable;
    logic [7:0]  read_data;
    logic        ready;
    logic        read_data_valid;

    modport slave (
        input  addr,
        input  write_data,
        input  write_enable,
        input  read_enable,
        output read_data,
        output ready,
        output read_data_valid
    );

    modport master (
        output addr,
        output write_data,
        output write_enable,
        output read_enable,
        input  read_data,
        input  ready,
        input  read_data_valid
    );
endinterface

interface burst_bus_if;
    logic [20:0] addr;
    logic        cmd;
    logic        cmd_en;
    logic [63:0] wr_data;
    logic [63:0] rd_data;
    logic [7:0]  data_mask;
    logic        ready;
    logic        rd_data_valid;

    modport master (
        output addr,
        output cmd,
        output cmd_en,
        output wr_data,
        output data_mask,
        input  rd_data,
        input  ready,
        input  rd_data_valid
    );

    modport slave (
        input  addr,
        input  cmd,
        input  cmd_en,
        input  wr_data,
        input  data_mask,
        output rd_data,
        output ready,
        output rd_data_valid
    );
endinterface

// File: rtl/debug_burst_bridge.sv
// Turns single-byte debug peeks/pokes into full byte-masked bursts on the
// 64-bit PSRAM burst port; read data comes back as one byte.

module debug_burst_bridge #(
    parameter int unsigned BURST_BEATS    = 4,
    parameter logic [20:0] BASE_ADDR      = 21'h0,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    debug_bus_if.slave  dbg,
    burst_bus_if.master mem,
    output logic        timeout_flag
);

    localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WBEAT,
        S_RWAIT,
        S_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           is_wr_q, is_wr_d;
    logic [20:0]    addr_q, addr_d;
    logic [2:0]     lane_q, lane_d;
    logic [63:0]    wr_data_q, wr_data_d;
    logic [7:0]     resp_q, resp_d;
    logic           rdv_q, rdv_d;
    logic           to_flag_q, to_flag_d;

    logic           cmd_fire;
    logic [7:0]     lane_mask;
    logic [63:0]    rd_shifted;
    logic [7:0]     rd_lane;

    // The controller accepts a command only in a cycle with ready high, so the
    // enable and the beat-0 mask are the registered command qualified by ready.
    assign cmd_fire   = (state_q == S_CMD) && mem.ready;
    assign lane_mask  = ~(8'h01 << lane_q);
    assign rd_shifted = mem.rd_data >> {lane_q, 3'b000};
    assign rd_lane    = rd_shifted[7:0];

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        to_cnt_d  = to_cnt_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        wr_data_d = wr_data_q;
        resp_d    = resp_q;
        rdv_d     = 1'b0;
        to_flag_d = to_flag_q;

        case (state_q)
            S_IDLE: begin
                if (dbg.write_enable || dbg.read_enable) begin
                    // A simultaneous read is dropped in favour of the write.
                    is_wr_d = dbg.write_enable;
                    addr_d  = BASE_ADDR + {5'b0, dbg.addr[15:3], 3'b000};
                    lane_d  = dbg.addr[2:0];
                    if (dbg.write_enable) begin
                        wr_data_d = {8{dbg.write_data}};
                    end
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                if (mem.ready) begin
                    if (is_wr_q) begin
                        if (BURST_BEATS > 1) begin
                            state_d = S_WBEAT;
                            beat_d  = BW'(1);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d  = S_RWAIT;
                        beat_d   = '0;
                        to_cnt_d = '0;
                    end
                end
            end

            S_WBEAT: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            S_RWAIT: begin
                if (mem.rd_data_valid) begin
                    if (beat_q == '0) begin
                        resp_d = rd_lane;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_RESP;
                        rdv_d   = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (to_cnt_q + 1'b1 == TO_LIMIT) begin
                    // Give up on the burst; late beats land outside RWAIT and are ignored.
                    resp_d    = 8'hFF;
                    to_flag_d = 1'b1;
                    state_d   = S_RESP;
                    rdv_d     = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            to_cnt_q  <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            lane_q    <= '0;
            wr_data_q <= '0;
            resp_q    <= '0;
            rdv_q     <= 1'b0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            to_cnt_q  <= to_cnt_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            lane_q    <= lane_d;
            wr_data_q <= wr_data_d;
            resp_q    <= resp_d;
            rdv_q     <= rdv_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign dbg.ready           = (state_q == S_IDLE);
    assign dbg.read_data_valid = rdv_q;
    assign dbg.read_data       = resp_q;

    assign mem.cmd_en    = cmd_fire;
    assign mem.cmd       = is_wr_q;
    assign mem.addr      = addr_q;
    assign mem.wr_data   = wr_data_q;
    assign mem.data_mask = (cmd_fire && is_wr_q) ? lane_mask : 8'hFF;

    assign timeout_flag = to_flag_q;

endmodule

// File: tb/tb_debug_burst_bridge.sv
// Directed plus randomized bench for debug_burst_bridge: a byte-addressed PSRAM
// model answers the burst port while a host-level model predicts every debug read.

module tb_debug_burst_bridge;

    localparam logic [20:0] BASE  = 21'h1F_FFF8;
    localparam int          TMO   = 16;
    localparam int          BEATS = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic timeout_flag;

    debug_bus_if dbg_if ();
    burst_bus_if mem_if ();

    debug_burst_bridge #(
        .BURST_BEATS   (BEATS),
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dbg         (dbg_if),
        .mem         (mem_if),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic exp_flag = 1'b0;

    logic [7:0] dev_mem  [logic [20:0]];
    logic [7:0] host_exp [logic [15:0]];

    function automatic logic [7:0] init_byte(input logic [20:0] pa);
        return pa[7:0] ^ {pa[12:8], 3'b000} ^ 8'h5A;
    endfunction

    function automatic logic [20:0] phys_byte(input logic [15:0] a);
        return BASE + 21'(a);
    endfunction

    function automatic logic [20:0] phys_word(input logic [15:0] a);
        return phys_byte(a) - 21'(a % 8);
    endfunction

    function automatic logic [7:0] dev_rd(input logic [20:0] pa);
        if (dev_mem.exists(pa)) return dev_mem[pa];
        return init_byte(pa);
    endfunction

    function automatic logic [7:0] host_expect(input logic [15:0] a);
        if (host_exp.exists(a)) return host_exp[a];
        return dev_rd(phys_byte(a));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, dbg_if.ready, 1);
        check({tag, "_rdv"}, dbg_if.read_data_valid, 0);
        check({tag, "_rdata"}, dbg_if.read_data, 0);
        check({tag, "_cmd_en"}, mem_if.cmd_en, 0);
        check({tag, "_cmd"}, mem_if.cmd, 0);
        check({tag, "_addr"}, mem_if.addr, 0);
        check({tag, "_wr_data"}, mem_if.wr_data, 0);
        check({tag, "_mask"}, mem_if.data_mask, 8'hFF);
        check({tag, "_tflag"}, timeout_flag, 0);
    endtask

    // Device side: commit unmasked lanes of the beat currently on the bus.
    task automatic dev_apply_beat(input logic [20:0] pa, input int k);
        for (int n = 0; n < 8; n++) begin
            if (!mem_if.data_mask[n]) dev_mem[pa + 21'(8 * k + n)] = mem_if.wr_data[8*n +: 8];
        end
    endtask

    task automatic idle_check();
        mem_if.ready = 1'b1;
        mem_if.rd_data_valid = 1'b0;
        #1;
        check("idle_ready", dbg_if.ready, 1);
        check("idle_cmd_en", mem_if.cmd_en, 0);
        check("idle_mask", mem_if.data_mask, 8'hFF);
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d, input int stall,
                              input logic also_rd);
        logic [20:0] pa;
        idle_check();
        dbg_if.addr = a;
        dbg_if.write_data = d;
        dbg_if.write_enable = 1'b1;
        dbg_if.read_enable = also_rd;
        tick();
        dbg_if.write_enable = 1'b0;
        dbg_if.read_enable = 1'b0;
        dbg_if.addr = 16'($urandom);
        dbg_if.write_data = 8'($urandom);
        for (int i = 0; i < stall; i++) begin
            mem_if.ready = 1'b0;
            #1;
            check("wr_stall_cmd_en", mem_if.cmd_en, 0);
            check("wr_stall_ready", dbg_if.ready, 0);
            check("wr_stall_mask", mem_if.data_mask, 8'hFF);
            tick();
        end
        mem_if.ready = 1'b1;
        #1;
        check("wr_cmd_en", mem_if.cmd_en, 1);
        check("wr_cmd", mem_if.cmd, 1);
        check("wr_addr", mem_if.addr, phys_word(a));
        check("wr_mask0", mem_if.data_mask, 8'hFF ^ (8'h01 << (a % 8)));
        check("wr_data0", mem_if.wr_data, {8{d}});
        pa = mem_if.addr;
        dev_apply_beat(pa, 0);
        tick();
        for (int k = 1; k < BEATS; k++) begin
            #1;
            check("wr_beat_cmd_en", mem_if.cmd_en, 0);
            check("wr_beat_mask", mem_if.data_mask, 8'hFF);
            check("wr_beat_ready", dbg_if.ready, 0);
            dev_apply_beat(pa, k);
            tick();
        end
        host_exp[a] = d;
    endtask

    task automatic host_read(input logic [15:0] a, input int gap, input logic no_resp);
        logic [20:0] pa;
        logic [63:0] w;
        idle_check();
        dbg_if.addr = a;
        dbg_if.read_enable = 1'b1;
        tick();
        dbg_if.read_enable = 1'b0;
        dbg_if.addr = 16'($urandom);
        #1;
        check("rd_cmd_en", mem_if.cmd_en, 1);
        check("rd_cmd", mem_if.cmd, 0);
        check("rd_addr", mem_if.addr, phys_word(a));
        check("rd_ready_low", dbg_if.ready, 0);
        pa = mem_if.addr;
        tick();
        if (!no_resp) begin
            for (int i = 0; i < gap; i++) begin
                mem_if.rd_data_valid = 1'b0;
                #1;
                check("rd_gap_rdv", dbg_if.read_data_valid, 0);
                tick();
            end
            for (int k = 0; k < BEATS; k++) begin
                for (int n = 0; n < 8; n++) w[8*n +: 8] = dev_rd(pa + 21'(8 * k + n));
                mem_if.rd_data = w;
                mem_if.rd_data_valid = 1'b1;
                #1;
                check("rd_beat_rdv", dbg_if.read_data_valid, 0);
                tick();
            end
            mem_if.rd_data_valid = 1'b0;
            mem_if.rd_data = 64'($urandom) << 32 | 64'($urandom);
            #1;
            check("rd_rdv", dbg_if.read_data_valid, 1);
            check("rd_data", dbg_if.read_data, host_expect(a));
            tick();
        end else begin
            for (int i = 0; i < TMO; i++) begin
                mem_if.rd_data_valid = 1'b0;
                #1;
                check("to_wait_rdv", dbg_if.read_data_valid, 0);
                check("to_wait_flag", timeout_flag, exp_flag);
                tick();
            end
            exp_flag = 1'b1;
            #1;
            check("to_rdv", dbg_if.read_data_valid, 1);
            check("to_data", dbg_if.read_data, 8'hFF);
            check("to_flag", timeout_flag, 1);
            mem_if.rd_data = 64'hDEAD_BEEF_0BAD_F00D;
            mem_if.rd_data_valid = 1'b1;
            tick();
            #1;
            check("to_stray_ready", dbg_if.ready, 1);
            check("to_stray_rdv", dbg_if.read_data_valid, 0);
            tick();
        end
        mem_if.rd_data_valid = 1'b0;
        #1;
        check("rd_rdv_after", dbg_if.read_data_valid, 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] wa;
        logic [7:0]  wd;
        rst_n = 1'b0;
        dbg_if.addr = '0;
        dbg_if.write_data = '0;
        dbg_if.write_enable = 1'b0;
        dbg_if.read_enable = 1'b0;
        mem_if.ready = 1'b0;
        mem_if.rd_data = '0;
        mem_if.rd_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Preload the word behind debug 0x0010..0x0017 with a known pattern.
        for (int n = 0; n < 8; n++) begin
            wd = 8'(64'h1122_3344_5566_7788 >> (8 * n));
            dev_mem[phys_word(16'h0010) + 21'(n)] = wd;
            host_exp[16'h0010 + 16'(n)] = wd;
        end
        host_read(16'h0013, 0, 1'b0);
        check("pattern_lane3", dbg_if.read_data, 8'h55);

        host_write(16'h0013, 8'hA5, 0, 1'b0);
        host_read(16'h0013, 2, 1'b0);
        host_read(16'h0012, 0, 1'b0);

        host_write(16'h0021, 8'h3C, 20, 1'b0);
        host_read(16'h0021, 1, 1'b0);

        host_read(16'h0005, 0, 1'b1);
        host_read(16'h0005, 3, 1'b0);

        host_write(16'hFFFF, 8'h96, 0, 1'b1);
        check("collide_wrapped_addr", phys_word(16'hFFFF), 21'h00_FFF0);
        idle_check();
        check("collide_no_read", dbg_if.read_data_valid, 0);
        host_read(16'hFFFF, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom % 2 == 0) ? 16'($urandom_range(0, 47)) : 16'hFFC0 + 16'($urandom_range(0, 63));
            if ($urandom % 2 == 0) begin
                host_write(ra, 8'($urandom), $urandom_range(0, 3), 1'($urandom));
            end else begin
                host_read(ra, $urandom_range(0, 5), 1'b0);
            end
        end

        // Reset while beat 2 of a write burst is on the bus.
        wa = 16'h002A;
        wd = 8'hC3;
        idle_check();
        dbg_if.addr = wa;
        dbg_if.write_data = wd;
        dbg_if.write_enable = 1'b1;
        tick();
        dbg_if.write_enable = 1'b0;
        #1;
        check("rst_wr_cmd_en", mem_if.cmd_en, 1);
        dev_apply_beat(mem_if.addr, 0);
        host_exp[wa] = wd;
        tick();
        tick();
        #1;
        check("rst_beat2_ready", dbg_if.ready, 0);
        rst_n = 1'b0;
        #1;
        exp_flag = 1'b0;
        check_reset_vals("rst_async");
        tick();
        check_reset_vals("rst_held");
        rst_n = 1'b1;
        tick();
        check("rst_after_cmd_en", mem_if.cmd_en, 0);
        check("rst_after_ready", dbg_if.ready, 1);
        tick();
        check("rst_after_cmd_en2", mem_if.cmd_en, 0);
        host_read(wa, 0, 1'b0);
        host_read(16'h0013, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
